// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes, instruction field positions, NOP encoding and ID/EX control struct.
// Used by decode (inst_d) and fetch.
package isa_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [5:0] OP_LDW  = 6'h0C;
  localparam logic [5:0] OP_STW  = 6'h0D;
  localparam logic [5:0] OP_BZ   = 6'h0E;
  localparam logic [5:0] OP_BEQ  = 6'h0F;
  localparam logic [5:0] OP_JR   = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h11;
  localparam logic [5:0] OP_NOP  = 6'h3F;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'hFC00_0000;

  typedef enum logic {S_RUN, S_HALTED} state_t;

  typedef struct packed {
    logic [REG_AW-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
  } ctrl_t;

  // Even opcodes in the ALU group write rd, odd ones (plus LDW) write rt.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode,
                                        input logic [REG_AW-1:0] rt,
                                        input logic [REG_AW-1:0] rd);
    ctrl_t c;
    c = '0;
    case (opcode)
      6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A: begin
        c.dest      = rd;
        c.reg_write = 1'b1;
      end
      6'h01, 6'h03, 6'h05, 6'h07, 6'h09, 6'h0B, 6'h0C: begin
        c.dest      = rt;
        c.reg_write = 1'b1;
      end
      default: ;
    endcase
    c.mem_read  = (opcode == OP_LDW);
    c.mem_write = (opcode == OP_STW);
    c.branch    = (opcode == OP_BZ) || (opcode == OP_BEQ) || (opcode == OP_JR);
    return c;
  endfunction

  function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two combinational reads and one write port; R0 is an ordinary register.
// WB_BYPASS_EN: a read of the register being written returns the write data in the same cycle.
module reg_file
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] i_rd_addr_a,
  input  logic [REG_AW-1:0] i_rd_addr_b,
  output logic [XLEN-1:0]   o_rd_data_a,
  output logic [XLEN-1:0]   o_rd_data_b,
  input  logic              i_wr_en,
  input  logic [REG_AW-1:0] i_wr_addr,
  input  logic [XLEN-1:0]   i_wr_data
);

  logic [XLEN-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

`ifdef WB_BYPASS_EN
  assign o_rd_data_a = (i_wr_en && (i_wr_addr == i_rd_addr_a)) ? i_wr_data : r_regs[i_rd_addr_a];
  assign o_rd_data_b = (i_wr_en && (i_wr_addr == i_rd_addr_b)) ? i_wr_data : r_regs[i_rd_addr_b];
`else
  assign o_rd_data_a = r_regs[i_rd_addr_a];
  assign o_rd_data_b = r_regs[i_rd_addr_b];
`endif

endmodule

// File: rtl/inst_d.sv
// Instruction decode stage: IF/ID register, decode, register file and ID/EX register with RUN/HALTED control.
// Optional macro WB_BYPASS_EN enables same-cycle writeback bypass in reg_file.
module inst_d
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_in,
  input  logic [31:0] pc_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  output logic [4:0]  rs_f_id,
  output logic [4:0]  rt_f_id,
  output logic [4:0]  rd_f_id,
  output logic [4:0]  id_dest,
  output logic        reg_write_f_id,
  output logic        ex_valid,
  output logic [5:0]  ex_opcode,
  output logic [31:0] ex_rs_val,
  output logic [31:0] ex_rt_val,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_dest,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        halted,
  output logic [31:0] inst_count
);

  logic [XLEN-1:0] r_ifid_instr;
  logic [XLEN-1:0] r_ifid_pc;
  logic            r_ifid_valid;

  state_t          r_state;
  logic            r_halted;
  logic            r_ex_valid;
  logic [5:0]      r_ex_opcode;
  logic [XLEN-1:0] r_ex_rs_val;
  logic [XLEN-1:0] r_ex_rt_val;
  logic [XLEN-1:0] r_ex_imm;
  logic [XLEN-1:0] r_ex_pc;
  ctrl_t           r_ex_ctrl;
  logic [XLEN-1:0] r_inst_count;

  logic [5:0]        w_opcode;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [XLEN-1:0]   w_imm;
  ctrl_t             w_ctrl;
  logic [XLEN-1:0]   w_rs_val;
  logic [XLEN-1:0]   w_rt_val;
  logic              w_load;

  assign w_opcode = r_ifid_instr[OPC_MSB:OPC_LSB];
  assign w_rs     = r_ifid_instr[RS_MSB:RS_LSB];
  assign w_rt     = r_ifid_instr[RT_MSB:RT_LSB];
  assign w_rd     = r_ifid_instr[RD_MSB:RD_LSB];
  assign w_imm    = sign_ext16(r_ifid_instr[IMM_MSB:IMM_LSB]);
  assign w_ctrl   = r_ifid_valid ? decode_ctrl(w_opcode, w_rt, w_rd) : '0;
  assign w_load   = (r_state == S_RUN) && !stall && !flush;

  reg_file u_reg_file (
    .clk         (clk),
    .rst         (rst),
    .i_rd_addr_a (w_rs),
    .i_rd_addr_b (w_rt),
    .o_rd_data_a (w_rs_val),
    .o_rd_data_b (w_rt_val),
    .i_wr_en     (wb_en),
    .i_wr_addr   (wb_dest),
    .i_wr_data   (wb_data)
  );

  // IF/ID: frozen once halted; flush takes priority over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= '0;
      r_ifid_valid <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (flush) begin
        r_ifid_instr <= NOP_INSTR;
        r_ifid_pc    <= '0;
        r_ifid_valid <= 1'b0;
      end else if (!stall) begin
        r_ifid_instr <= instruction_in;
        r_ifid_pc    <= pc_in;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_halted     <= 1'b0;
      r_ex_valid   <= 1'b0;
      r_ex_opcode  <= '0;
      r_ex_rs_val  <= '0;
      r_ex_rt_val  <= '0;
      r_ex_imm     <= '0;
      r_ex_pc      <= '0;
      r_ex_ctrl    <= '0;
      r_inst_count <= '0;
    end else begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      if (w_load) begin
        r_ex_valid  <= r_ifid_valid;
        r_ex_opcode <= w_opcode;
        r_ex_rs_val <= w_rs_val;
        r_ex_rt_val <= w_rt_val;
        r_ex_imm    <= w_imm;
        r_ex_pc     <= r_ifid_pc;
        r_ex_ctrl   <= w_ctrl;
        if (r_ifid_valid) begin
          r_inst_count <= r_inst_count + 32'd1;
          if (w_opcode == OP_HALT) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end
        end
      end
    end
  end

  assign rs_f_id        = w_rs;
  assign rt_f_id        = w_rt;
  assign rd_f_id        = w_rd;
  assign id_dest        = w_ctrl.dest;
  assign reg_write_f_id = w_ctrl.reg_write;

  assign ex_valid     = r_ex_valid;
  assign ex_opcode    = r_ex_opcode;
  assign ex_rs_val    = r_ex_rs_val;
  assign ex_rt_val    = r_ex_rt_val;
  assign ex_imm       = r_ex_imm;
  assign ex_pc        = r_ex_pc;
  assign ex_dest      = r_ex_ctrl.dest;
  assign ex_reg_write = r_ex_ctrl.reg_write;
  assign ex_mem_read  = r_ex_ctrl.mem_read;
  assign ex_mem_write = r_ex_ctrl.mem_write;
  assign ex_branch    = r_ex_ctrl.branch;
  assign halted       = r_halted;
  assign inst_count   = r_inst_count;

endmodule

// File: doc/inst_d.md
INST_D -- requirements
Module: inst_d

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; rst  in  1  synchronous, active-high reset.
REQ-002 SHALL have instruction_in  in  32  fetched word; pc_in  in  32  its byte PC; stall  in  1  hold decode; flush  in  1  kill decode (taken branch/JR).
REQ-003 SHALL have wb_en  in  1, wb_dest  in  5, wb_data  in  32  register-file write port from writeback.
REQ-004 SHALL have rs_f_id, rt_f_id, rd_f_id  out  5 each  fields of held instruction; id_dest  out  5; reg_write_f_id  out  1  hazard feedback to fetch.
REQ-005 SHALL have ex_valid  out  1, ex_opcode  out  6, ex_rs_val/ex_rt_val/ex_imm/ex_pc  out  32 each, ex_dest  out  5, ex_reg_write/ex_mem_read/ex_mem_write/ex_branch  out  1 each  ID/EX register.
REQ-006 SHALL have halted  out  1  sticky halt; inst_count  out  32  retired-to-EX count.

Function
REQ-007 SHALL capture instruction_in/pc_in into IF/ID register on each clk edge when stall=0 and flush=0; latency IF/ID -> ID/EX is exactly one cycle.
REQ-008 SHALL decode fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to 32 bits.
REQ-009 SHALL set dest = rd for opcodes 0x00,0x02,0x04,0x06,0x08,0x0A; dest = rt for 0x01,0x03,0x05,0x07,0x09,0x0B,0x0C; reg_write=1 for all of these.
REQ-010 SHALL set dest=0, reg_write=0 for STW 0x0D, BZ 0x0E, BEQ 0x0F, JR 0x10, HALT 0x11, NOP 0x3F and any undefined opcode.
REQ-011 SHALL assert mem_read only for 0x0C, mem_write only for 0x0D, branch only for 0x0E/0x0F/0x10.
REQ-012 SHALL read ex_rs_val/ex_rt_val combinationally from a 32x32 register file; write on clk edge when wb_en=1; all 32 registers writable including R0.
REQ-013 SHALL drive id_dest/reg_write_f_id from IF/ID contents combinationally every cycle, zero when IF/ID holds a bubble.
REQ-014 stall=1: IF/ID holds; ID/EX loads a bubble (ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, ex_branch=0).
REQ-015 flush=1: IF/ID loads NOP (0xFC000000, valid=0); ID/EX loads a bubble; flush wins over simultaneous stall.
REQ-016 SHALL implement states RUN and HALTED: RUN -> HALTED on the edge a valid HALT enters ID/EX; HALTED exits only on rst.
REQ-017 In HALTED: halted=1, ID/EX loads bubbles every cycle, IF/ID frozen, register-file writes still accepted.
REQ-018 inst_count SHALL increment by 1 on each edge a valid non-bubble instruction enters ID/EX, wrapping 0xFFFFFFFF -> 0.
REQ-019 Undefined opcodes SHALL pass as valid with all control bits 0 and SHALL count.

Reset
REQ-020 rst=1 at a clk edge SHALL clear IF/ID to NOP, all ID/EX outputs to 0, halted=0, inst_count=0, state=RUN, all registers to 0, overriding wb_en, stall, flush and an in-flight HALT.

Configuration
REQ-021 WB_BYPASS_EN defined: a read whose address equals wb_dest while wb_en=1 SHALL return wb_data in the same cycle; undefined: read returns the stored value (new value visible next cycle).

Structure
REQ-022 Opcode constants, field positions/widths, NOP encoding and the ID/EX control struct SHALL live in shared package isa_pkg, also used by fetch.
REQ-023 Register file SHALL be sub-module reg_file (2 read, 1 write, bypass under WB_BYPASS_EN).

Verification
REQ-024 ADDI R3,R0,5 (0x04030005) at pc 0x0 -> next cycle ex_dest=3, ex_reg_write=1, ex_imm=5, ex_pc=0, inst_count=1.
REQ-025 ADDI imm 0xFFFF -> ex_imm=0xFFFFFFFF; STW R4 -> reg_write_f_id=0, id_dest=0, ex_mem_write=1.
REQ-026 stall=1 and flush=1 together with ADD in IF/ID -> IF/ID=NOP, ex_valid=0, inst_count unchanged.
REQ-027 wb_en=1, wb_dest=7, wb_data=0xDEADBEEF while reading R7 -> 0xDEADBEEF same cycle with WB_BYPASS_EN, old value without; next cycle both 0xDEADBEEF.
REQ-028 HALT (0x44000000) then ADD -> halted=1 after one edge, ex_valid=0 thereafter, inst_count stops; rst=1 -> halted=0, inst_count=0.
